// File: rtl/fx2_stream_in_ctrl.sv
// fx2_stream_in_ctrl
// Buffers upstream words in a small FIFO and writes them into the FX2 slave
// FIFO endpoint, honouring the endpoint FULL flag. It counts words within the
// current USB packet. A partial packet is committed with PKTEND either on a
// flush request or after an idle timeout. Full packets are committed by the
// FX2 itself.
module fx2_stream_in_ctrl #(
  parameter int         DATA_W     = 16,
  parameter int         FIFO_DEPTH = 16,
  parameter int         PKT_LEN    = 256,
  parameter int         TIMEOUT    = 1024,
  parameter logic [1:0] FADDR      = 2'b10
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          in_ready,
  input  logic                          flush,
  input  logic                          flagd_n,
  output logic [DATA_W-1:0]             fd,
  output logic [1:0]                    faddr,
  output logic                          slwr_n,
  output logic                          slrd_n,
  output logic                          sloe_n,
  output logic                          pkt_end_n,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int WCW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int TW  = 16;

  localparam logic [LW-1:0]  LEVEL_FULL = LW'(FIFO_DEPTH);
  localparam logic [WCW-1:0] WC_LAST    = WCW'(PKT_LEN - 1);
  localparam logic [TW-1:0]  TMO_LIMIT  = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_PKTEND = 2'd2
  } state_t;

  // Buffer storage and pointers
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [LW-1:0]     level_reg;

  // Controller state and registered pin drivers
  state_t            state_reg;
  logic [DATA_W-1:0] fd_reg;
  logic              slwr_n_reg;
  logic              pkt_end_n_reg;
  logic [WCW-1:0]    wc_reg;
  logic              flush_pend_reg;
  logic [TW-1:0]     tmo_reg;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic can_write;
  logic pop;
  logic tmo_hit;
  logic pe_fire;

  assign fifo_full  = (level_reg == LEVEL_FULL);
  assign fifo_empty = (level_reg == '0);
  assign push       = in_valid && !fifo_full;

  // A write edge is possible whenever the host side permits it and data waits
  assign can_write  = enable && flagd_n && !fifo_empty;

  // Words leave the buffer only on edges where the FX2 strobe is driven low
  assign pop        = (state_reg == S_WRITE) && can_write;

  // Timeout only counts while a partial packet is outstanding; 0 disables it
  assign tmo_hit    = (TIMEOUT != 0) && (tmo_reg >= TMO_LIMIT);

  // Commit a partial packet once it is safe: flag not full, something to
  // commit, and either a drained flush or an expired idle timer
  assign pe_fire    = (state_reg == S_IDLE) && flagd_n && (wc_reg != '0) &&
                      ((flush_pend_reg && fifo_empty) || tmo_hit);

  // Buffer write port; no reset so the array can map to block RAM
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= in_data;
    end
  end

  // Buffer pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Write/commit sequencer with registered strobes and data bus
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      fd_reg        <= '0;
      slwr_n_reg    <= 1'b1;
      pkt_end_n_reg <= 1'b1;
    end else begin
      case (state_reg)
        S_IDLE: begin
          slwr_n_reg    <= 1'b1;
          pkt_end_n_reg <= 1'b1;
          if (pe_fire) begin
            // The strobe is low for exactly the one cycle spent in S_PKTEND
            pkt_end_n_reg <= 1'b0;
            state_reg     <= S_PKTEND;
          end else if (can_write) begin
            state_reg <= S_WRITE;
          end
        end
        S_WRITE: begin
          pkt_end_n_reg <= 1'b1;
          if (can_write) begin
            fd_reg     <= mem[rd_ptr_reg];
            slwr_n_reg <= 1'b0;
          end else begin
            // fd keeps the last written word while the strobe is released
            slwr_n_reg <= 1'b1;
            state_reg  <= S_IDLE;
          end
        end
        S_PKTEND: begin
          pkt_end_n_reg <= 1'b1;
          slwr_n_reg    <= 1'b1;
          state_reg     <= S_IDLE;
        end
        default: begin
          slwr_n_reg    <= 1'b1;
          pkt_end_n_reg <= 1'b1;
          state_reg     <= S_IDLE;
        end
      endcase
    end
  end

  // Packet word count, sticky flush request and idle timer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wc_reg         <= '0;
      flush_pend_reg <= 1'b0;
      tmo_reg        <= '0;
    end else if (pe_fire) begin
      wc_reg         <= '0;
      flush_pend_reg <= 1'b0;
      tmo_reg        <= '0;
    end else begin
      if (pop) begin
        // A full packet is committed by the FX2 itself, so just wrap
        wc_reg <= (wc_reg == WC_LAST) ? '0 : wc_reg + 1'b1;
      end
      // With nothing counted in the current packet a flush has nothing to
      // commit; this also drops a request left over from a full-packet wrap
      if (wc_reg == '0) begin
        flush_pend_reg <= 1'b0;
      end else if (flush) begin
        flush_pend_reg <= 1'b1;
      end
      if (pop) begin
        tmo_reg <= '0;
      end else if ((wc_reg != '0) && (tmo_reg < TMO_LIMIT)) begin
        tmo_reg <= tmo_reg + 1'b1;
      end
    end
  end

  assign in_ready  = !fifo_full;
  assign level     = level_reg;
  assign fd        = fd_reg;
  assign slwr_n    = slwr_n_reg;
  assign pkt_end_n = pkt_end_n_reg;
  assign faddr     = FADDR;
  assign slrd_n    = 1'b1;
  assign sloe_n    = 1'b1;

endmodule

// File: tb/tb_fx2_stream_in_ctrl.sv
// Randomised and directed bench for fx2_stream_in_ctrl with a queue-based
// reference model compared on every falling clock edge.
module tb_fx2_stream_in_ctrl;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int PLEN  = 4;
  localparam int TMO   = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          flush = 1'b0;
  logic          flagd_n = 1'b1;
  logic          in_ready;
  logic [DW-1:0] fd;
  logic [1:0]    faddr;
  logic          slwr_n;
  logic          slrd_n;
  logic          sloe_n;
  logic          pkt_end_n;
  logic [LW-1:0] level;

  always #5 clk = ~clk;

  fx2_stream_in_ctrl #(
    .DATA_W(DW), .FIFO_DEPTH(DEPTH), .PKT_LEN(PLEN), .TIMEOUT(TMO), .FADDR(2'b10)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .flush(flush), .flagd_n(flagd_n),
    .fd(fd), .faddr(faddr), .slwr_n(slwr_n), .slrd_n(slrd_n), .sloe_n(sloe_n),
    .pkt_end_n(pkt_end_n), .level(level)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] sb[$];
  int            m_phase = 0;      // 0 waiting, 1 streaming, 2 committing
  int            m_wc = 0;
  int            m_tmo = 0;
  bit            m_pend = 0;
  logic [DW-1:0] e_fd = '0;
  bit            e_slwr = 1;
  bit            e_pe = 1;
  bit            flag_prev = 1;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_q.delete(); sb.delete();
        m_phase = 0; m_wc = 0; m_tmo = 0; m_pend = 0;
        e_fd = '0; e_slwr = 1; e_pe = 1; flag_prev = 1;
      end else begin
        bit can_wr, do_push, do_wr, do_pe, hit;
        can_wr  = enable && flagd_n && (m_q.size() != 0);
        do_push = in_valid && (m_q.size() < DEPTH);
        hit     = (TMO != 0) && (m_tmo >= TMO);
        do_wr   = 0;
        do_pe   = 0;
        if (m_phase == 1) begin
          if (can_wr) do_wr = 1; else m_phase = 0;
        end else if (m_phase == 2) begin
          m_phase = 0;
        end else begin
          if (flagd_n && m_wc != 0 && ((m_pend && m_q.size() == 0) || hit)) begin
            do_pe = 1; m_phase = 2;
          end else if (can_wr) begin
            m_phase = 1;
          end
        end
        m_pend = do_pe ? 0 : (m_wc == 0) ? 0 : (m_pend || flush);
        if (do_wr || do_pe) m_tmo = 0;
        else if (m_wc != 0 && m_tmo < TMO) m_tmo++;
        if (do_pe) m_wc = 0;
        else if (do_wr) m_wc = (m_wc + 1) % PLEN;
        if (do_wr) e_fd = m_q.pop_front();
        if (do_push) begin
          m_q.push_back(in_data);
          sb.push_back(in_data);
        end
        e_slwr = !do_wr;
        e_pe = !do_pe;
        flag_prev = flagd_n;
      end
    end
  end

  // ---------------- compare / monitor ----------------
  int            wr_count = 0;
  int            pe_count = 0;
  int            last_wr_cyc = 0;
  int            last_pe_cyc = 0;
  logic [DW-1:0] wr_log[$];
  int            wr_cyc[$];

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        chk("slwr_n", slwr_n, e_slwr);
        chk("pkt_end_n", pkt_end_n, e_pe);
        chk("fd", fd, e_fd);
        chk("level", level, m_q.size());
        chk("in_ready", in_ready, (m_q.size() < DEPTH));
        chk("faddr", faddr, 2'b10);
        chk("slrd_sloe", {slrd_n, sloe_n}, 2'b11);
        if (slwr_n == 1'b0) begin
          wr_count++;
          last_wr_cyc = cyc;
          wr_log.push_back(fd);
          wr_cyc.push_back(cyc);
          if (sb.size() == 0) chk("sb_spurious_write", fd, 'x);
          else chk("sb_order", fd, sb.pop_front());
          if (!flag_prev) chk("write_while_full", slwr_n, 1'b1);
        end
        if (pkt_end_n == 1'b0) begin
          pe_count++;
          last_pe_cyc = cyc;
          chk("strobes_exclusive", slwr_n, 1'b1);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_n(int n);
    in_valid = 0;
    flush = 0;
    repeat (n) tick();
  endtask

  task automatic push_word(logic [DW-1:0] d);
    int g = 0;
    in_valid = 1;
    in_data = d;
    while (m_q.size() >= DEPTH && g < 200) begin
      tick();
      g++;
    end
    if (g >= 200) chk("push_wait_expired", g, 0);
    tick();
    in_valid = 0;
  endtask

  task automatic wait_writes(int target, string name);
    int g = 0;
    while (wr_count < target && g < 100) begin
      tick();
      g++;
    end
    chk(name, (wr_count >= target), 1'b1);
  endtask

  function automatic logic [DW-1:0] wr_at(int i);
    if (i < wr_log.size()) return wr_log[i];
    return 'x;
  endfunction

  function automatic int wcyc_at(int i);
    if (i < wr_cyc.size()) return wr_cyc[i];
    return -1000;
  endfunction

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_fd"}, fd, 0);
    chk({tag, "_slwr_n"}, slwr_n, 1);
    chk({tag, "_pkt_end_n"}, pkt_end_n, 1);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_faddr"}, faddr, 2'b10);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=expired required=finish");
    $fatal(1, "simulation time limit");
  end

  // ---------------- test sequence ----------------
  initial begin
    int base, pbase, first_push, gap;

    repeat (3) tick();
    chk_reset_outputs("por");
    reset_n = 1;
    idle_n(2);

    // Four words: latency 2, back-to-back strobes, wrap without PKTEND
    enable = 1; flagd_n = 1;
    base = wr_count; pbase = pe_count;
    push_word(16'h0001);
    first_push = cyc;
    push_word(16'h0002);
    push_word(16'h0003);
    push_word(16'h0004);
    wait_writes(base + 4, "t1_writes_done");
    chk("t1_latency", wcyc_at(base) - first_push, 2);
    for (int i = 0; i < 4; i++) begin
      chk("t1_fd_seq", wr_at(base + i), 16'(i + 1));
      if (i > 0) chk("t1_consecutive", wcyc_at(base + i) - wcyc_at(base + i - 1), 1);
    end
    idle_n(3);
    chk("t1_level_empty", level, 0);
    chk("t1_no_pktend", pe_count - pbase, 0);

    // Two full packets of 4: no PKTEND
    base = wr_count; pbase = pe_count;
    for (int i = 0; i < 8; i++) push_word(16'(32'h10 + i));
    wait_writes(base + 8, "t2_writes_done");
    idle_n(12);
    chk("t2_write_count", wr_count - base, 8);
    chk("t2_no_pktend", pe_count - pbase, 0);
    for (int i = 0; i < 8; i++) chk("t2_fd_seq", wr_at(base + i), 16'(32'h10 + i));

    // Three words then flush: one PKTEND two cycles after last write
    base = wr_count; pbase = pe_count;
    for (int i = 0; i < 3; i++) push_word(16'(32'h20 + i));
    wait_writes(base + 3, "t3_writes_done");
    flush = 1; tick(); flush = 0;
    idle_n(6);
    chk("t3_one_pktend", pe_count - pbase, 1);
    chk("t3_pktend_gap", last_pe_cyc - last_wr_cyc, 2);
    flush = 1; tick(); flush = 0;
    idle_n(12);
    chk("t3_empty_flush_no_pulse", pe_count - pbase, 1);

    // Idle timeout commits a two-word packet
    base = wr_count; pbase = pe_count;
    push_word(16'h0030);
    push_word(16'h0031);
    wait_writes(base + 2, "t5_writes_done");
    idle_n(16);
    chk("t5_one_pktend", pe_count - pbase, 1);
    gap = last_pe_cyc - last_wr_cyc;
    chk("t5_timeout_gap_9_10", (gap >= 9 && gap <= 10), 1'b1);
    if (!(gap >= 9 && gap <= 10)) $display("FAIL t5_gap actual=%0d required=9..10", gap);

    // Fill to full with writes disabled, then stream with a 5-cycle full flag
    base = wr_count; pbase = pe_count;
    enable = 0;
    for (int i = 0; i < 16; i++) push_word(16'(32'h100 + i));
    chk("t4_level_full", level, 16);
    chk("t4_in_ready_low", in_ready, 0);
    enable = 1;
    repeat (4) tick();
    flagd_n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_flag_low_no_write", slwr_n, 1);
    end
    flagd_n = 1;
    for (int i = 16; i < 20; i++) push_word(16'(32'h100 + i));
    wait_writes(base + 20, "t4_writes_done");
    idle_n(6);
    chk("t4_write_count", wr_count - base, 20);
    for (int i = 0; i < 20; i++) chk("t4_fd_seq", wr_at(base + i), 16'(32'h100 + i));

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 99) < 60);
      in_data  = DW'($urandom);
      enable   = ($urandom_range(0, 99) < 90);
      flagd_n  = ($urandom_range(0, 99) < 80);
      flush    = ($urandom_range(0, 99) < 3);
      tick();
    end
    enable = 1; flagd_n = 1;
    idle_n(40);
    chk("rand_drained", level, 0);

    // Reset in the middle of a burst
    for (int i = 0; i < 6; i++) push_word(16'(32'h200 + i));
    #2 reset_n = 0;
    #1 chk_reset_outputs("midrst");
    tick();
    tick();
    chk_reset_outputs("midrst_hold");
    reset_n = 1;
    idle_n(2);
    base = wr_count;
    push_word(16'hABCD);
    first_push = cyc;
    wait_writes(base + 1, "rst_first_write");
    chk("rst_first_word", wr_at(base), 16'hABCD);
    chk("rst_latency", wcyc_at(base) - first_push, 2);
    idle_n(4);
    chk("rst_single_write", wr_count - base, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
